keypad_display_system: RTL and testbench
========================================

Name: keypad_display_system

Overview:
Top-level block for the board's 4x4 matrix keypad and 4-digit 7-segment display. It scans the keypad rows, detects and debounces key presses, and encodes each press as a hex code 0x0–0xF. It shows the last four codes on the multiplexed display and outputs a running press count on gpio_out.

Parameters:
clk_freq, 50000000, system clock frequency in Hz
uart_baud_rate, 1152000, kept for interface compatibility with the SoC top; no functional effect in this block
scan_hz, 1000000, row-slot rate; each row is driven for clk_freq/scan_hz cycles (50 at defaults)
display_hz, 1000, digit-slot rate; each digit is lit for clk_freq/display_hz cycles

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  reset, synchronous, active-high
columnas  in  4  keypad column sense, active-high; bit i = column i
filas  out  4  keypad row drive, one-hot active-high; bit r = row r
seg  out  7  segment drive, active-low; bit order {g,f,e,d,c,b,a}
an  out  4  digit enable, active-low; an[0] = rightmost digit
gpio_out  out  8  count of accepted key presses

Behaviour:
- Reset (rst=1 at a clk edge) clears all state:
  - filas=4'b0001, row/digit dividers=0, code history=16'h0000, gpio_out=0.
  - an=4'b1110, seg=7'b1000000 (digit "0").
  - Reset mid-scan or mid-debounce aborts everything; no partial press is ever counted.
- Scan:
  - The row counter advances 0→1→2→3→0 every clk_freq/scan_hz cycles; filas = one-hot of the row counter.
  - columnas is sampled on the last cycle of each row slot and registered; there is no combinational path to the outputs.
  - A frame is 4 row slots (row0..row3).
  - At frame end, the frame result is hit/no-hit. On hit, code = 4*row + col of the lowest (row, col) pair sampled high, with row priority before column. Example: columnas=4'b0100 in every slot gives code 2.
- Press detection (state machine IDLE / PRESSED):
  - IDLE: a hit frame accepts a press (subject to the optional debounce). Acceptance shifts the code into history as history <= {history[11:0], code}, increments gpio_out (mod 256, 8'hFF→8'h00), and moves to PRESSED.
  - PRESSED: hit frames are ignored, including a different code, so there is one event per press. A no-hit frame returns to IDLE.
  - Latency: the accept takes effect one cycle after the frame's final sample.
- Display:
  - The digit counter cycles 0..3 every clk_freq/display_hz cycles.
  - an is the active-low one-hot of the digit counter.
  - Digit d shows history[4d+3:4d] as hex 0–F with standard 7-segment glyphs (A, b, C, d, E, F).
  - seg and an are registered and change on the same edge.
- Divider terminal count = clk_freq/N − 1. A divisor below 1 is clamped to 1.

Optional Feature:
KEYPAD_DEBOUNCE_EN
- Defined: IDLE accepts a press only after 3 consecutive hit frames with the same code. A no-hit frame or a code change restarts the count. Release still needs just one no-hit frame.
- Undefined: a single hit frame is accepted. Registered sampling is the only filtering.

Test Plan:
- Reset: hold rst=1 for 4 cycles → filas=0001, an=1110, seg=1000000, gpio_out=0. After release, filas steps 0001→0010→0100→1000 every 50 cycles at default parameters.
- Single press: columnas=4'b0100 held for 10 µs, then 0 for 10 µs → gpio_out=1, history=16'h0002, digit0 shows "2" (seg=0100100 while an=1110).
- Held key: columnas=4 held for 100 µs → gpio_out increments exactly once.
- Four press/release cycles of columnas=4 → gpio_out=4, history=16'h2222, all four digits show "2".
- Row-specific key: drive columnas[3]=1 only while filas=1000 → code F; digit0 shows "F" (seg=0001110).
- Debounce: with KEYPAD_DEBOUNCE_EN defined, a 2-frame glitch gives no count and a 3-frame hold gives +1. Without the macro, the 2-frame glitch counts.

Source files
------------

// File: rtl/keypad_display_system.sv
// 4x4 keypad scanner with press detection, hex history display and press counter.
// Optional build macro: KEYPAD_DEBOUNCE_EN (require 3 identical hit frames before accepting).
module keypad_display_system #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 1152000,
  parameter int scan_hz        = 1000000,
  parameter int display_hz     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [7:0] gpio_out
);

  localparam int ROW_RAW = (scan_hz < 1) ? clk_freq : clk_freq / scan_hz;
  localparam int ROW_DIV = (ROW_RAW < 1) ? 1 : ROW_RAW;
  localparam int ROW_TC  = ROW_DIV - 1;
  localparam int ROW_W   = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
  localparam int DIG_RAW = (display_hz < 1) ? clk_freq : clk_freq / display_hz;
  localparam int DIG_DIV = (DIG_RAW < 1) ? 1 : DIG_RAW;
  localparam int DIG_TC  = DIG_DIV - 1;
  localparam int DIG_W   = (DIG_DIV > 1) ? $clog2(DIG_DIV) : 1;

  // The baud rate only exists for the SoC wrapper; reject nonsense values at elaboration.
  if (uart_baud_rate < 1) begin : g_baud_check
    $error("uart_baud_rate must be positive");
  end

  typedef enum logic [0:0] {ST_IDLE, ST_PRESSED} state_t;

  logic [ROW_W-1:0] row_div_r;
  logic [1:0]       row_cnt_r;
  logic [3:0]       filas_r;
  logic             acc_hit_r;
  logic [3:0]       acc_code_r;
  logic             frame_done_r;
  logic             frame_hit_r;
  logic [3:0]       frame_code_r;
  logic             slot_end_s;
  logic             samp_hit_s;
  logic [1:0]       samp_col_s;
  logic             cur_hit_s;
  logic [3:0]       cur_code_s;

  state_t           state_r, state_s;
  logic [15:0]      history_r, history_s;
  logic [7:0]       count_r, count_s;

  logic [DIG_W-1:0] dig_div_r;
  logic [1:0]       dig_cnt_r;
  logic [6:0]       seg_r;
  logic [3:0]       an_r;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      4'hF:    g = 7'b0001110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Current slot's sample folded into the frame accumulator (first hit in row/col order wins).
  always_comb begin
    slot_end_s = (row_div_r == ROW_TC[ROW_W-1:0]);
    samp_hit_s = |columnas;
    if (columnas[0]) begin
      samp_col_s = 2'd0;
    end else if (columnas[1]) begin
      samp_col_s = 2'd1;
    end else if (columnas[2]) begin
      samp_col_s = 2'd2;
    end else begin
      samp_col_s = 2'd3;
    end
    if ((row_cnt_r == 2'd0) || !acc_hit_r) begin
      cur_hit_s  = samp_hit_s;
      cur_code_s = {row_cnt_r, samp_col_s};
    end else begin
      cur_hit_s  = 1'b1;
      cur_code_s = acc_code_r;
    end
  end

  // Row scanning, slot-end sampling and frame result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_div_r    <= '0;
      row_cnt_r    <= 2'd0;
      filas_r      <= 4'b0001;
      acc_hit_r    <= 1'b0;
      acc_code_r   <= 4'h0;
      frame_done_r <= 1'b0;
      frame_hit_r  <= 1'b0;
      frame_code_r <= 4'h0;
    end else begin
      frame_done_r <= 1'b0;
      if (slot_end_s) begin
        row_div_r  <= '0;
        row_cnt_r  <= row_cnt_r + 2'd1;
        filas_r    <= {filas_r[2:0], filas_r[3]};
        acc_hit_r  <= cur_hit_s;
        acc_code_r <= cur_code_s;
        if (row_cnt_r == 2'd3) begin
          frame_done_r <= 1'b1;
          frame_hit_r  <= cur_hit_s;
          frame_code_r <= cur_code_s;
        end
      end else begin
        row_div_r <= row_div_r + ROW_W'(1);
      end
    end
  end

`ifdef KEYPAD_DEBOUNCE_EN
  logic [1:0] deb_cnt_r, deb_cnt_s;
  logic [3:0] deb_code_r, deb_code_s;
`endif

  // Press FSM next-state: one accepted event per press, released by a no-hit frame.
  always_comb begin
    state_s   = state_r;
    history_s = history_r;
    count_s   = count_r;
`ifdef KEYPAD_DEBOUNCE_EN
    deb_cnt_s  = deb_cnt_r;
    deb_code_s = deb_code_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (frame_done_r && frame_hit_r) begin
`ifdef KEYPAD_DEBOUNCE_EN
          if ((deb_cnt_r != 2'd0) && (frame_code_r == deb_code_r)) begin
            deb_cnt_s = deb_cnt_r + 2'd1;
          end else begin
            deb_cnt_s = 2'd1;
          end
          deb_code_s = frame_code_r;
          if (deb_cnt_s == 2'd3) begin
            deb_cnt_s = 2'd0;
            history_s = {history_r[11:0], frame_code_r};
            count_s   = count_r + 8'd1;
            state_s   = ST_PRESSED;
          end else begin
            state_s = ST_IDLE;
          end
`else
          history_s = {history_r[11:0], frame_code_r};
          count_s   = count_r + 8'd1;
          state_s   = ST_PRESSED;
`endif
        end else if (frame_done_r) begin
`ifdef KEYPAD_DEBOUNCE_EN
          deb_cnt_s = 2'd0;
`endif
          state_s = ST_IDLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (frame_done_r && !frame_hit_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PRESSED;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Press FSM state, history and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      history_r <= 16'h0000;
      count_r   <= 8'h00;
`ifdef KEYPAD_DEBOUNCE_EN
      deb_cnt_r  <= 2'd0;
      deb_code_r <= 4'h0;
`endif
    end else begin
      state_r   <= state_s;
      history_r <= history_s;
      count_r   <= count_s;
`ifdef KEYPAD_DEBOUNCE_EN
      deb_cnt_r  <= deb_cnt_s;
      deb_code_r <= deb_code_s;
`endif
    end
  end

  // Digit multiplexing; seg and an are loaded together from the same digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_div_r <= '0;
      dig_cnt_r <= 2'd0;
      seg_r     <= 7'b1000000;
      an_r      <= 4'b1110;
    end else begin
      if (dig_div_r == DIG_TC[DIG_W-1:0]) begin
        dig_div_r <= '0;
        dig_cnt_r <= dig_cnt_r + 2'd1;
      end else begin
        dig_div_r <= dig_div_r + DIG_W'(1);
      end
      seg_r <= hex_glyph(history_r[{dig_cnt_r, 2'b00} +: 4]);
      an_r  <= ~(4'b0001 << dig_cnt_r);
    end
  end

  assign filas    = filas_r;
  assign seg      = seg_r;
  assign an       = an_r;
  assign gpio_out = count_r;

endmodule

// File: tb/tb_keypad_display_system.sv
// Directed bench for keypad_display_system: reset, scan stepping, table of presses, corner sequences.
module tb_keypad_display_system;

  logic       clk;
  logic       rst;
  logic [3:0] columnas;
  logic [3:0] filas;
  logic [6:0] seg;
  logic [3:0] an;
  logic [7:0] gpio_out;

  int checks = 0;
  int errors = 0;

  localparam int FRAME = 200; // 4 row slots of 50 cycles at default scan settings

  keypad_display_system #(
    .clk_freq(50000000),
    .uart_baud_rate(1152000),
    .scan_hz(1000000),
    .display_hz(5000000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .columnas(columnas),
    .filas(filas),
    .seg(seg),
    .an(an),
    .gpio_out(gpio_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [3:0]  cols;
    int          hold;
    int          rel;
    logic [7:0]  exp_cnt;
    logic [15:0] exp_hist;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    logic [6:0] t[16];
    t[0]  = 7'b1000000; t[1]  = 7'b1111001; t[2]  = 7'b0100100; t[3]  = 7'b0110000;
    t[4]  = 7'b0011001; t[5]  = 7'b0010010; t[6]  = 7'b0000010; t[7]  = 7'b1111000;
    t[8]  = 7'b0000000; t[9]  = 7'b0010000; t[10] = 7'b0001000; t[11] = 7'b0000011;
    t[12] = 7'b1000110; t[13] = 7'b0100001; t[14] = 7'b0000110; t[15] = 7'b0001110;
    return t[n];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves us at the first negedge of a row-0 slot.
  task automatic align_frame();
    int b = 0;
    while (filas != 4'b1000 && b < 1000) begin @(negedge clk); b++; end
    while (filas == 4'b1000 && b < 1000) begin @(negedge clk); b++; end
    if (b >= 1000) timeout("align_frame");
  endtask

  task automatic press(input logic [3:0] cols, input int hold, input int rel);
    align_frame();
    columnas = cols;
    tick(hold * FRAME);
    columnas = 4'b0000;
    tick(rel * FRAME);
  endtask

  task automatic check_state(input string tag, input logic [7:0] cnt, input logic [15:0] hist);
    logic [3:0] want_an;
    logic [3:0] nib;
    int b;
    chk({tag, "_gpio"}, gpio_out, cnt);
    for (int d = 0; d < 4; d++) begin
      want_an = 4'b0001 << d;
      want_an = ~want_an;
      nib = hist[4*d +: 4];
      b = 0;
      while (an != want_an && b < 200) begin @(negedge clk); b++; end
      if (b >= 200) timeout({tag, "_an_wait"});
      else chk($sformatf("%s_seg_d%0d", tag, d), seg, ref_glyph(nib));
    end
  endtask

  initial begin
    vecs[0] = '{4'b0100, 4, 3, 8'd1, 16'h0002};
    vecs[1] = '{4'b0100, 25, 3, 8'd2, 16'h0022};
    vecs[2] = '{4'b0001, 4, 3, 8'd3, 16'h0220};
    vecs[3] = '{4'b1010, 4, 3, 8'd4, 16'h2201};
    vecs[4] = '{4'b1000, 4, 3, 8'd5, 16'h2013};

    rst = 1'b1;
    columnas = 4'b0000;
    tick(4);
    chk("rst_filas", filas, 4'b0001);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_gpio", gpio_out, 8'd0);

    rst = 1'b0;
    tick(49);  chk("scan_row0_end", filas, 4'b0001);
    tick(1);   chk("scan_row1", filas, 4'b0010);
    tick(50);  chk("scan_row2", filas, 4'b0100);
    tick(50);  chk("scan_row3", filas, 4'b1000);
    tick(50);  chk("scan_wrap", filas, 4'b0001);

    for (int i = 0; i < 5; i++) begin
      press(vecs[i].cols, vecs[i].hold, vecs[i].rel);
      check_state($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_hist);
    end

    // Reset in the middle of a frame with a key down: nothing may be counted.
    align_frame();
    columnas = 4'b0100;
    tick(150);
    rst = 1'b1;
    tick(1);
    columnas = 4'b0000;
    tick(1);
    rst = 1'b0;
    tick(3 * FRAME);
    check_state("midrst", 8'd0, 16'h0000);

    for (int i = 0; i < 4; i++) press(4'b0100, 4, 3);
    check_state("four2", 8'd4, 16'h2222);

    // Key in row 3, column 3 only: drive the column only while row 3 is active.
    align_frame();
    for (int i = 0; i < 4 * FRAME; i++) begin
      columnas = filas[3] ? 4'b1000 : 4'b0000;
      @(negedge clk);
    end
    columnas = 4'b0000;
    tick(3 * FRAME);
    check_state("rowF", 8'd5, 16'h222F);

    press(4'b0001, 2, 3);
`ifdef KEYPAD_DEBOUNCE_EN
    check_state("glitch", 8'd5, 16'h222F);
    press(4'b0001, 3, 3);
    check_state("hold3", 8'd6, 16'h22F0);
`else
    check_state("glitch", 8'd6, 16'h22F0);
    press(4'b0001, 3, 3);
    check_state("hold3", 8'd7, 16'h2F00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
